// File: rtl/sr_cmd_gen.sv
// Command sequencer for a downstream SR flop. It turns set/clear request pulses
// into sr codes that are held for HOLD_CYCLES and followed by a 00 gap. The
// code 11 is never issued, and requests the flop already satisfies are dropped.
module sr_cmd_gen #(
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned CLR_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    input  logic       q_fb,
    output logic [1:0] sr,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] drop_cnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DROP_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic CLR_WINS = (CLR_PRIORITY != 0);

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOLD = 2'd1,
        CLR_HOLD = 2'd2,
        GAP      = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                pend_set_q, pend_set_d;
    logic                pend_clr_q, pend_clr_d;
    logic [1:0]          sr_q,       sr_d;
    logic                busy_q,     busy_d;
    logic                conflict_q, conflict_d;
    logic [DROP_W-1:0]   drop_q,     drop_d;

    logic                both_req;
    logic                set_in;
    logic                clr_in;
    logic                pick_set;
    logic                pick_clr;
    logic                serve_set;
    logic                serve_clr;
    logic                redundant;
    logic [1:0]          drop_inc;
    logic [DROP_W:0]     drop_sum;

    // Request capture and arbitration between pending flags.
    always_comb begin
        both_req = set_req & clr_req;
        set_in   = set_req & ~(both_req & CLR_WINS);
        clr_in   = clr_req & ~(both_req & ~CLR_WINS);
        pick_clr = pend_clr_q & (CLR_WINS | ~pend_set_q);
        pick_set = pend_set_q & ~pick_clr;
    end

    // Next-state, pending flags, drop counter and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        serve_set  = 1'b0;
        serve_clr  = 1'b0;
        redundant  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_set) begin
                    serve_set = 1'b1;
                    if (q_fb) begin
                        redundant = 1'b1;
                    end else begin
                        state_d = SET_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (pick_clr) begin
                    serve_clr = 1'b1;
                    if (!q_fb) begin
                        redundant = 1'b1;
                    end else begin
                        state_d = CLR_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            SET_HOLD, CLR_HOLD: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request sampled on the edge that retires the old one counts as new.
        pend_set_d = (pend_set_q & ~serve_set) | set_in;
        pend_clr_d = (pend_clr_q & ~serve_clr) | clr_in;

        conflict_d = both_req;
        drop_inc   = {1'b0, both_req} + {1'b0, redundant};
        drop_sum   = (DROP_W+1)'(drop_q) + (DROP_W+1)'(drop_inc);
        drop_d     = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

        case (state_d)
            SET_HOLD: sr_d = SR_SET;
            CLR_HOLD: sr_d = SR_CLR;
            default:  sr_d = SR_HOLD;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            sr_q       <= SR_HOLD;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            sr_q       <= sr_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            drop_q     <= drop_d;
        end
    end

    assign sr       = sr_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: stimulus pushes the expected outputs for each
// clock edge, and a negedge monitor pops and compares them.
module tb_sr_cmd_gen;

    logic       clk;
    logic       rst;
    logic       set_req;
    logic       clr_req;
    logic       q_fb;
    logic [1:0] sr;
    logic       busy;
    logic       conflict;
    logic [7:0] drop_cnt;

    logic       q_fb_drv;
    logic       use_model;
    logic       flop_q;
    logic [1:0] prev_sr;

    typedef struct packed {
        logic [1:0]  sr;
        logic        busy;
        logic        conflict;
        logic [7:0]  drop;
        logic [15:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   tag_base;
    int   tag_idx;

    sr_cmd_gen #(
        .HOLD_CYCLES (2),
        .GAP_CYCLES  (1),
        .CLR_PRIORITY(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .clr_req (clr_req),
        .q_fb    (q_fb),
        .sr      (sr),
        .busy    (busy),
        .conflict(conflict),
        .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the downstream SR flop, or a direct q_fb drive.
    always @(posedge clk) begin
        if (!use_model)         flop_q <= q_fb_drv;
        else if (sr == 2'b10)   flop_q <= 1'b1;
        else if (sr == 2'b01)   flop_q <= 1'b0;
    end
    assign q_fb = use_model ? flop_q : q_fb_drv;

    task automatic check_vec(input exp_t e);
        vectors++;
        if (sr !== e.sr || busy !== e.busy || conflict !== e.conflict || drop_cnt !== e.drop) begin
            miscompares++;
            $display("FAIL vec%0d: got sr=%b busy=%b conflict=%b drop_cnt=%0d, expected sr=%b busy=%b conflict=%b drop_cnt=%0d",
                     e.tag, sr, busy, conflict, drop_cnt, e.sr, e.busy, e.conflict, e.drop);
        end
    endtask

    // Monitor: compare against the scoreboard, and check the sr invariants every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec(e);
        end
        if (rst) begin
            prev_sr <= 2'b00;
        end else begin
            if (sr == 2'b11) begin
                miscompares++;
                $display("FAIL sr_illegal: got sr=%b, expected never 11", sr);
            end
            if (sr != 2'b00 && prev_sr != 2'b00 && sr != prev_sr) begin
                miscompares++;
                $display("FAIL sr_direct_swap: got sr %b -> %b, expected a 00 between codes", prev_sr, sr);
            end
            prev_sr <= sr;
        end
    end

    function automatic logic [15:0] next_tag();
        tag_idx++;
        return 16'(tag_base * 1000 + tag_idx);
    endfunction

    // Apply one cycle of inputs; queue the outputs expected after the edge that samples them.
    task automatic step(input logic s, input logic c, input logic [1:0] e_sr,
                        input logic e_busy, input logic e_conf, input logic [7:0] e_drop);
        exp_t e;
        set_req = s;
        clr_req = c;
        @(posedge clk);
        #1;
        e.sr       = e_sr;
        e.busy     = e_busy;
        e.conflict = e_conf;
        e.drop     = e_drop;
        e.tag      = next_tag();
        exp_q.push_back(e);
        set_req = 1'b0;
        clr_req = 1'b0;
    endtask

    // Reset between edges; the reset outputs are queued for the next monitor sample.
    task automatic do_reset(input int test_id);
        exp_t e;
        tag_base = test_id;
        tag_idx  = 0;
        @(negedge clk);
        #2;
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        e.sr       = 2'b00;
        e.busy     = 1'b0;
        e.conflict = 1'b0;
        e.drop     = 8'd0;
        e.tag      = next_tag();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    initial begin
        exp_t e;
        int   wait_cnt;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        set_req     = 1'b0;
        clr_req     = 1'b0;
        q_fb_drv    = 1'b0;
        use_model   = 1'b0;
        prev_sr     = 2'b00;
        tag_base    = 0;
        tag_idx     = 0;

        // 1: single set with q_fb=0 -> 10 for two cycles, one gap cycle, then idle.
        do_reset(1);
        step(1, 0, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b10, 1, 0, 8'd0);
        step(0, 0, 2'b10, 1, 0, 8'd0);
        step(0, 0, 2'b00, 1, 0, 8'd0);
        step(0, 0, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b00, 0, 0, 8'd0);

        // 2: simultaneous set+clr with q_fb=1 -> conflict pulse, set dropped, clear issued.
        q_fb_drv = 1'b1;
        do_reset(2);
        step(1, 1, 2'b00, 0, 1, 8'd1);
        step(0, 0, 2'b01, 1, 0, 8'd1);
        step(0, 0, 2'b01, 1, 0, 8'd1);
        step(0, 0, 2'b00, 1, 0, 8'd1);
        step(0, 0, 2'b00, 0, 0, 8'd1);
        step(0, 0, 2'b00, 0, 0, 8'd1);
        step(0, 0, 2'b00, 0, 0, 8'd1);

        // 3: redundant set with q_fb=1 -> no command, one drop.
        do_reset(3);
        step(1, 0, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b00, 0, 0, 8'd1);
        step(0, 0, 2'b00, 0, 0, 8'd1);

        // 4: clear, then a set arriving during CLR_HOLD, with q_fb from the flop model.
        q_fb_drv = 1'b1;
        do_reset(4);
        use_model = 1'b1;
        step(1'b0, 1'b1, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b01, 1, 0, 8'd0);
        step(1, 0, 2'b01, 1, 0, 8'd0);
        step(0, 0, 2'b00, 1, 0, 8'd0);
        step(0, 0, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b10, 1, 0, 8'd0);
        step(0, 0, 2'b10, 1, 0, 8'd0);
        step(0, 0, 2'b00, 1, 0, 8'd0);
        step(0, 0, 2'b00, 0, 0, 8'd0);
        use_model = 1'b0;

        // 5: reset mid SET_HOLD with a second set pending -> immediate clear, no later command.
        q_fb_drv = 1'b0;
        do_reset(5);
        step(1, 0, 2'b00, 0, 0, 8'd0);
        step(0, 0, 2'b10, 1, 0, 8'd0);
        step(1, 0, 2'b10, 1, 0, 8'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        e.sr = 2'b00; e.busy = 1'b0; e.conflict = 1'b0; e.drop = 8'd0; e.tag = next_tag();
        check_vec(e);
        e.tag = next_tag();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00, 0, 0, 8'd0);

        // 6: 300 redundant sets -> drop_cnt saturates at 255.
        q_fb_drv = 1'b1;
        do_reset(6);
        for (int i = 1; i <= 300; i++) begin
            step(1, 0, 2'b00, 0, 0, sat(i - 1));
            step(0, 0, 2'b00, 0, 0, sat(i));
        end

        // Drain the scoreboard with a bound.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
